// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: tracks the longest matched PATTERN prefix using a KMP
// transition table built at elaboration, with a registered match pulse and a saturating counter.
module seq_pattern_detector #(
  parameter int unsigned       N       = 5,
  parameter logic [N-1:0]      PATTERN = 5'b11011,
  parameter int unsigned       OVERLAP = 0,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x,
  input  logic                   en,
  input  logic                   clr,
  output logic                   y,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [$clog2(N)-1:0]   state_o
);

  localparam int unsigned SW = $clog2(N);

  // Bit of PATTERN received in position pos (pos 0 is the first bit on the wire).
  function automatic logic pat_bit(input int unsigned pos);
    logic [N-1:0] sh;
    sh = PATTERN >> (N - 1 - pos);
    return sh[0];
  endfunction

  // Longest k <= max_k such that the first k PATTERN bits equal the last k bits
  // of the string (first s PATTERN bits followed by b).
  function automatic int unsigned fail_len(input int unsigned s, input logic b,
                                           input int unsigned max_k);
    int unsigned res;
    int unsigned idx;
    logic        ok;
    logic        sb;
    res = 0;
    for (int unsigned k = 1; k <= max_k; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        idx = s + 1 - k + j;
        sb  = (idx == s) ? b : pat_bit(idx);
        if (sb != pat_bit(j)) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  function automatic int unsigned next_state(input int unsigned s, input logic b);
    if (s < N - 1 && b == pat_bit(s)) return s + 1;
    if (s == N - 1 && b == PATTERN[0])
      return (OVERLAP != 0) ? fail_len(N - 1, PATTERN[0], N - 1) : 0;
    return fail_len(s, b, s);
  endfunction

  logic [SW-1:0] nxt0 [N];
  logic [SW-1:0] nxt1 [N];

  for (genvar g = 0; g < N; g++) begin : g_tbl
    localparam int unsigned NS0 = next_state(g, 1'b0);
    localparam int unsigned NS1 = next_state(g, 1'b1);
    assign nxt0[g] = SW'(NS0);
    assign nxt1[g] = SW'(NS1);
  end

  logic [SW-1:0]    s_q,   s_d;
  logic             y_q,   y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;

  always_comb begin
    s_d   = s_q;
    y_d   = 1'b0;
    cnt_d = cnt_q;
    match = en && (s_q == SW'(N - 1)) && (x == PATTERN[0]);
    if (en) begin
      s_d = x ? nxt1[s_q] : nxt0[s_q];
    end
    y_d = match;
    if (clr) begin
      cnt_d = '0;
    end else if (match && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign state_o   = s_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: three instances (non-overlap, overlap,
// 2-bit counter) share one input stream; expectations are hand-derived for 11011.
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, x = 1'b0, en = 1'b0, clr = 1'b0;
  logic       y0, y1, y2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] st0, st1, st2;

  int compared   = 0;
  int mismatched = 0;

  seq_pattern_detector #(.N(5), .PATTERN(5'b11011), .OVERLAP(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y0), .match_cnt(cnt0), .state_o(st0));

  seq_pattern_detector #(.N(5), .PATTERN(5'b11011), .OVERLAP(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y1), .match_cnt(cnt1), .state_o(st1));

  seq_pattern_detector #(.N(5), .PATTERN(5'b11011), .OVERLAP(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y2), .match_cnt(cnt2), .state_o(st2));

  task automatic step(input logic xi, input logic ei, input logic ci, input logic ri);
    x = xi; en = ei; clr = ci; rst = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stream 1,1,0,1,1,0,1,1
  logic a_x  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  int   a_s0 [8] = '{1, 2, 3, 4, 0, 0, 1, 2};
  int   a_y0 [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int   a_s1 [8] = '{1, 2, 3, 4, 2, 3, 4, 2};
  int   a_y1 [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  // Stream 1,1,1,0,1,1
  logic c_x  [6] = '{1, 1, 1, 0, 1, 1};
  int   c_s0 [6] = '{1, 2, 2, 3, 4, 0};
  int   c_y0 [6] = '{0, 0, 0, 0, 0, 1};
  // Pattern bits in arrival order
  logic p_x  [5] = '{1, 1, 0, 1, 1};
  int   p_s  [5] = '{1, 2, 3, 4, 0};

  initial begin
    // Reset with en=1, x=1 asserted
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_state", st0, 0);
    chk("rst_y", y0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt2", cnt2, 0);

    // Non-overlap vs overlap on 11011011
    for (int i = 0; i < 8; i++) begin
      step(a_x[i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("a_s0[%0d]", i), st0, a_s0[i]);
      chk($sformatf("a_y0[%0d]", i), y0, a_y0[i]);
      chk($sformatf("a_s1[%0d]", i), st1, a_s1[i]);
      chk($sformatf("a_y1[%0d]", i), y1, a_y1[i]);
    end
    chk("a_cnt0", cnt0, 1);
    chk("a_cnt1", cnt1, 2);

    // Failure transition on the extra 1 of 111011
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(c_x[i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("c_s0[%0d]", i), st0, c_s0[i]);
      chk($sformatf("c_y0[%0d]", i), y0, c_y0[i]);
    end
    chk("c_cnt0", cnt0, 1);

    // 1101, en low for three cycles with x toggling, then final 1
    for (int i = 0; i < 4; i++) begin
      step(p_x[i], 1'b1, 1'b0, 1'b0);
      chk($sformatf("d_s0[%0d]", i), st0, p_s[i]);
    end
    for (int i = 0; i < 3; i++) begin
      step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("d_gap_y[%0d]", i), y0, 0);
      chk($sformatf("d_gap_s[%0d]", i), st0, 4);
    end
    chk("d_gap_cnt", cnt0, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("d_final_y", y0, 1);
    chk("d_final_s", st0, 0);
    chk("d_final_cnt", cnt0, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("d_en0_y", y0, 0);
    chk("d_en0_s", st0, 0);

    // 110, reset, 11
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("e_s[0]", st0, 1); chk("e_y[0]", y0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("e_s[1]", st0, 2); chk("e_y[1]", y0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0); chk("e_s[2]", st0, 3); chk("e_y[2]", y0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1); chk("e_rst_s", st0, 0); chk("e_rst_y", y0, 0);
    chk("e_rst_cnt", cnt0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("e_s[3]", st0, 1); chk("e_y[3]", y0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("e_s[4]", st0, 2); chk("e_y[4]", y0, 0);

    // Complete to 1101, then reset on the completing bit: no match
    step(1'b0, 1'b1, 1'b0, 1'b0); chk("f_s3", st0, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("f_s4", st0, 4);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("f_rst_y", y0, 0);
    chk("f_rst_s", st0, 0);
    chk("f_rst_cnt", cnt0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("f_post_rst_y", y0, 0);

    // Four back-to-back matches: 2-bit counter saturates at 3
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 5; i++) begin
        step(p_x[i], 1'b1, 1'b0, 1'b0);
        chk($sformatf("g_s2[%0d.%0d]", m, i), st2, p_s[i]);
      end
      chk($sformatf("g_y2[%0d]", m), y2, 1);
      chk($sformatf("g_cnt2[%0d]", m), cnt2, (m < 3) ? m + 1 : 3);
    end
    chk("g_cnt0", cnt0, 4);

    // clr together with a match: counter cleared, pulse and state unaffected
    for (int i = 0; i < 4; i++) step(p_x[i], 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("h_clr_cnt2", cnt2, 0);
    chk("h_clr_cnt0", cnt0, 0);
    chk("h_clr_y2", y2, 1);
    chk("h_clr_s2", st2, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("h_clr_only_s", st2, 1);
    chk("h_clr_only_y", y2, 0);
    chk("h_clr_only_cnt", cnt2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 SHALL have parameter N, default 5, meaning pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 5'b11011, meaning the target sequence; PATTERN[N-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 0, meaning 0 = non-overlapping detection, 1 = overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port x, input, 1 bit: serial data bit.
REQ-008 SHALL have port en, input, 1 bit: x is sampled only when en=1.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear of the match counter only.
REQ-010 SHALL have port y, output, 1 bit: registered Mealy match pulse.
REQ-011 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-012 SHALL have port state_o, output, ceil(log2(N)) bits: current matched-prefix length, for debug.

Function
REQ-013 SHALL hold state S in 0..N-1; S = number of leading PATTERN bits matched by the most recent sampled bits.
REQ-014 SHALL, on a sampled bit x with S<N-1 that equals the expected bit PATTERN[N-1-S], set S to S+1.
REQ-015 SHALL, on a sampled mismatch, set S to the length of the longest proper prefix of PATTERN that is a suffix of (matched bits followed by x), i.e. the KMP failure transition; 0 if none.
REQ-016 SHALL compute the failure/next-state table from PATTERN at elaboration; no runtime pattern load.
REQ-017 SHALL declare a match when S=N-1, en=1 and x=PATTERN[0].
REQ-018 SHALL, on a match with OVERLAP=0, set S to 0.
REQ-019 SHALL, on a match with OVERLAP=1, set S to the longest proper border of PATTERN.
REQ-020 SHALL register y: y=1 for exactly one cycle, in the cycle after the edge that sampled the completing bit; y=0 otherwise.
REQ-021 SHALL, when en=0, hold S and match_cnt and drive y=0 at the next edge.
REQ-022 SHALL increment match_cnt by 1 on each match and saturate at 2^CNT_W-1 with no wrap-around.
REQ-023 SHALL, when clr=1, load match_cnt with 0; clr takes priority over a same-cycle increment; S and y are unaffected.
REQ-024 SHALL accept back-to-back sampled bits every cycle with no stall or bubble.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, set S=0, y=0 and match_cnt=0, regardless of en, clr or x.
REQ-026 SHALL let rst override any in-progress partial match; no match is declared in the reset cycle.
REQ-027 SHALL resume sampling on the first edge at which rst=0.

Verification (N=5, PATTERN=11011, CNT_W=8 unless noted; en=1 throughout unless noted)
REQ-028 SHALL pass this check: with OVERLAP=0 and stream 1,1,0,1,1,0,1,1, y pulses once (after bit 5) and match_cnt=1.
REQ-029 SHALL pass this check: with OVERLAP=1 and the same stream, y pulses after bit 5 and after bit 8, and match_cnt=2.
REQ-030 SHALL pass this check: stream 1,1,1,0,1,1 gives S sequence 1,2,2,3,4 then a y pulse after bit 6, proving the failure transition on the extra 1.
REQ-031 SHALL pass this check: stream 1,1,0,1 then en=0 for 3 cycles with x toggling, then en=1 with x=1 gives no y during the gap and one pulse after the final bit.
REQ-032 SHALL pass this check: stream 1,1,0, then rst=1 for one cycle, then 1,1 gives y=0 throughout and S=2 at the end.
REQ-033 SHALL pass this check: with CNT_W=2 and OVERLAP=0, 4 matches give match_cnt=3 (saturated); clr together with a match gives match_cnt=0.
